// File: rtl/compare_arb_pkg.sv
// Shared types and constants for the compare arbiter: FSM states, default sizes
// and bit positions of the result flags.
package compare_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_DATA_W = 4;

  localparam int N_FLAGS = 3;
  localparam int FLAG_EQ = 0;
  localparam int FLAG_LT = 1;
  localparam int FLAG_GT = 2;

endpackage

// File: rtl/compare_arbiter_if.sv
// Request/operand/result bundle between the requesting control blocks (master)
// and the shared compare arbiter (slave).
interface compare_arbiter_if
  import compare_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        REQ;
  logic [N_REQ*DATA_W-1:0] PORTA_IN;
  logic [N_REQ*DATA_W-1:0] PORTB_IN;
  logic [N_REQ-1:0]        GNT;
  logic                    BUSY;
  logic                    VALID;
  logic                    READY;
  logic [ID_W-1:0]         RES_ID;
  logic                    EQUAL;
  logic                    LESS;
  logic                    HIGHER;

  modport master (
    output REQ, PORTA_IN, PORTB_IN, READY,
    input  GNT, BUSY, VALID, RES_ID, EQUAL, LESS, HIGHER
  );

  modport slave (
    input  REQ, PORTA_IN, PORTB_IN, READY,
    output GNT, BUSY, VALID, RES_ID, EQUAL, LESS, HIGHER
  );

endinterface

// File: rtl/compare_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching from i_ptr
// upward with wrap-around. Returns one-hot winner, its index and any-request.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_win,
  output logic [ID_W-1:0]  o_win_id,
  output logic             o_any
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [ID_W-1:0]    w_pos;
  logic               w_found;
  logic [ID_W:0]      w_sum;

  // Rotating the doubled vector right by ptr puts the search start at bit 0.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N_REQ-1:0];
  assign o_any = |i_req;

  always_comb begin
    w_pos   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!w_found && w_rot[i]) begin
        w_pos   = ID_W'(i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, i_ptr} + {1'b0, w_pos};
    if (w_sum >= (ID_W+1)'(N_REQ)) begin
      o_win_id = ID_W'(w_sum - (ID_W+1)'(N_REQ));
    end else begin
      o_win_id = w_sum[ID_W-1:0];
    end
    o_win = '0;
    if (o_any) begin
      o_win[o_win_id] = 1'b1;
    end
  end

endmodule

// File: rtl/compare_arbiter.sv
// One unsigned magnitude comparator shared by N_REQ requesters: round-robin
// grant, operand latch, registered EQUAL/LESS/HIGHER held under VALID/READY.
module compare_arbiter
  import compare_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  compare_arbiter_if.slave  bus
);

  localparam int ID_W = $clog2(N_REQ);

  state_t              r_state;
  state_t              w_state_next;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [N_FLAGS-1:0]  r_flags;
  logic [N_REQ-1:0]    r_gnt;

  logic [N_REQ-1:0]    w_win;
  logic [ID_W-1:0]     w_win_id;
  logic                w_any;
  logic                w_take;
  logic                w_done;
  logic [N_FLAGS-1:0]  w_cmp;
  logic [ID_W-1:0]     w_ptr_next;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .i_req    (bus.REQ),
    .i_ptr    (r_ptr),
    .o_win    (w_win),
    .o_win_id (w_win_id),
    .o_any    (w_any)
  );

  assign w_take     = (r_state == ST_IDLE) && w_any;
  assign w_done     = (r_state == ST_RESP) && bus.READY;
  assign w_ptr_next = (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + 1'b1;

  always_comb begin
    w_cmp          = '0;
    w_cmp[FLAG_EQ] = (r_a == r_b);
    w_cmp[FLAG_LT] = (r_a <  r_b);
    w_cmp[FLAG_GT] = (r_a >  r_b);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_any)     w_state_next = ST_CMP;
      ST_CMP:                 w_state_next = ST_RESP;
      ST_RESP: if (bus.READY) w_state_next = ST_IDLE;
      default:                w_state_next = ST_IDLE;
    endcase
  end

  // Flags are cleared on the handshake so they read zero whenever VALID is low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr   <= '0;
      r_id    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_flags <= '0;
      r_gnt   <= '0;
    end else begin
      r_gnt <= w_take ? w_win : '0;
      if (w_take) begin
        r_id <= w_win_id;
        r_a  <= bus.PORTA_IN[int'(w_win_id)*DATA_W +: DATA_W];
        r_b  <= bus.PORTB_IN[int'(w_win_id)*DATA_W +: DATA_W];
      end
      if (r_state == ST_CMP) begin
        r_flags <= w_cmp;
      end else if (w_done) begin
        r_flags <= '0;
        r_ptr   <= w_ptr_next;
      end
    end
  end

  always_comb begin
    bus.GNT    = r_gnt;
    bus.BUSY   = (r_state != ST_IDLE);
    bus.VALID  = (r_state == ST_RESP);
    bus.RES_ID = r_id;
    bus.EQUAL  = r_flags[FLAG_EQ];
    bus.LESS   = r_flags[FLAG_LT];
    bus.HIGHER = r_flags[FLAG_GT];
  end

endmodule

// File: tb/tb_compare_arbiter.sv
// Self-checking bench for compare_arbiter: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_compare_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  compare_arbiter_if #(.N_REQ(N), .DATA_W(W)) bif ();

  compare_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bif)
  );

  int errors = 0;
  int checks = 0;

  // Model: m_age < 0 no transaction, 0 = grant cycle, 1 = result on offer.
  int m_ptr = 0;
  int m_id  = 0;
  int m_a   = 0;
  int m_b   = 0;
  int m_age = -1;

  typedef struct {
    int         rq;
    int         a;
    int         b;
    logic [2:0] f;   // {HIGHER, LESS, EQUAL}
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_edge();
    if (rst) begin
      m_ptr = 0;
      m_id  = 0;
      m_age = -1;
    end else if (m_age < 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (bif.REQ[idx]) begin
          m_id  = idx;
          m_a   = int'((bif.PORTA_IN >> (idx * W)) & ((1 << W) - 1));
          m_b   = int'((bif.PORTB_IN >> (idx * W)) & ((1 << W) - 1));
          m_age = 0;
          break;
        end
      end
    end else if (m_age == 0) begin
      m_age = 1;
    end else if (bif.READY) begin
      m_ptr = (m_id + 1) % N;
      m_age = -1;
    end
  endfunction

  task automatic model_check();
    logic [N-1:0] eg;
    logic [2:0]   ef;
    logic [1:0]   eid;
    logic         v;
    logic [31:0]  act;
    logic [31:0]  exp;
    v   = (m_age == 1);
    eg  = (m_age == 0) ? N'(1 << m_id) : '0;
    ef  = v ? {m_a > m_b, m_a < m_b, m_a == m_b} : 3'b000;
    eid = v ? 2'(m_id) : 2'd0;
    exp = {21'd0, eg, m_age >= 0, v, ef, eid};
    act = {21'd0, bif.GNT, bif.BUSY, bif.VALID, bif.HIGHER, bif.LESS, bif.EQUAL,
           bif.VALID ? bif.RES_ID : 2'd0};
    check("cycle_model", act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic do_txn(input logic [N-1:0] req, input int exp_id, input string name);
    bif.REQ      = req;
    bif.READY    = 1'b1;
    bif.PORTA_IN = 16'($urandom);
    bif.PORTB_IN = 16'($urandom);
    step();
    check(name, bif.GNT, 32'(1 << exp_id));
    step();
    step();
  endtask

  logic [31:0] saved;

  initial begin
    tbl[0] = '{2, 9,  3,  3'b100};
    tbl[1] = '{0, 15, 15, 3'b001};
    tbl[2] = '{0, 0,  15, 3'b010};
    tbl[3] = '{0, 8,  7,  3'b100};
    tbl[4] = '{3, 5,  5,  3'b001};
    tbl[5] = '{1, 0,  1,  3'b010};
    tbl[6] = '{2, 15, 0,  3'b100};

    bif.REQ      = '0;
    bif.PORTA_IN = '0;
    bif.PORTB_IN = '0;
    bif.READY    = 1'b0;
    rst          = 1'b1;
    step();
    check("reset_valid", {bif.VALID, bif.BUSY, bif.GNT}, 0);
    check("reset_id_flags", {bif.RES_ID, bif.HIGHER, bif.LESS, bif.EQUAL}, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      bif.REQ      = N'(1 << tbl[i].rq);
      bif.PORTA_IN = 16'($urandom);
      bif.PORTB_IN = 16'($urandom);
      bif.PORTA_IN[tbl[i].rq*W +: W] = W'(tbl[i].a);
      bif.PORTB_IN[tbl[i].rq*W +: W] = W'(tbl[i].b);
      bif.READY    = 1'b1;
      step();
      check("tbl_gnt", bif.GNT, 32'(1 << tbl[i].rq));
      check("tbl_valid_early", bif.VALID, 0);
      bif.REQ = '0;
      step();
      check("tbl_valid", bif.VALID, 1);
      check("tbl_gnt_pulse", bif.GNT, 0);
      check("tbl_id", bif.RES_ID, tbl[i].rq);
      check("tbl_flags", {bif.HIGHER, bif.LESS, bif.EQUAL}, tbl[i].f);
      step();
      check("tbl_valid_one_cycle", bif.VALID, 0);
    end

    rst = 1'b1;
    step();
    rst = 1'b0;
    do_txn(4'b1111, 0, "fair_0");
    do_txn(4'b1111, 1, "fair_1");
    do_txn(4'b1111, 2, "fair_2");
    do_txn(4'b1111, 3, "fair_3");
    do_txn(4'b1111, 0, "fair_4");
    do_txn(4'b1111, 1, "fair_5");
    do_txn(4'b1010, 3, "fair_1010_a");
    do_txn(4'b1010, 1, "fair_1010_b");

    bif.REQ      = 4'b0100;
    bif.READY    = 1'b0;
    bif.PORTA_IN = 16'($urandom);
    bif.PORTB_IN = 16'($urandom);
    step();
    bif.REQ = '0;
    step();
    check("bp_valid", bif.VALID, 1);
    saved = {26'd0, bif.VALID, bif.RES_ID, bif.HIGHER, bif.LESS, bif.EQUAL};
    for (int c = 0; c < 6; c++) begin
      bif.PORTA_IN = 16'($urandom);
      bif.PORTB_IN = 16'($urandom);
      bif.REQ      = 4'($urandom) | 4'b0001;
      step();
      check("bp_hold", {26'd0, bif.VALID, bif.RES_ID, bif.HIGHER, bif.LESS, bif.EQUAL}, saved);
      check("bp_no_gnt", bif.GNT, 0);
    end
    bif.READY = 1'b1;
    step();
    check("bp_release", {bif.VALID, bif.GNT}, 0);
    bif.READY = 1'b0;
    step();
    check("bp_regrant", bif.GNT != '0, 1);
    bif.REQ   = '0;
    bif.READY = 1'b1;
    step();
    step();

    bif.REQ   = 4'b1000;
    bif.READY = 1'b0;
    step();
    bif.REQ = '0;
    step();
    check("rst_pre_id", {bif.VALID, bif.RES_ID}, 3'b111);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_clear", {bif.VALID, bif.BUSY, bif.HIGHER, bif.LESS, bif.EQUAL}, 0);
    do_txn(4'b1111, 0, "rst_regrant_0");

    do_txn(4'b0010, 1, "held_1a");
    do_txn(4'b0010, 1, "held_1b");
    do_txn(4'b1010, 3, "held_other_3");
    do_txn(4'b0010, 1, "held_1c");
    do_txn(4'b0011, 0, "held_wrap_0");

    for (int c = 0; c < 400; c++) begin
      bif.REQ      = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      bif.PORTA_IN = 16'($urandom);
      bif.PORTB_IN = 16'($urandom);
      bif.READY    = ($urandom_range(0, 2) != 0);
      rst          = ($urandom_range(0, 39) == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
